// File: rtl/imm_decode_ctrl_pkg.sv
// Shared immediate-type codes and RV32I opcode constants for the ID-stage
// immediate decode/extend path.
package imm_decode_ctrl_pkg;

  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5,
    ZTYPE = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_ctrl_immextend.sv
// Combinational immediate extender: rebuilds the 32-bit immediate from the
// instruction fields above the opcode according to the immediate type.
module ImmExtend
  import imm_decode_ctrl_pkg::*;
(
  input  logic [31:7] inst_i,
  input  imm_type_e   imm_type_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (imm_type_i)
      ITYPE:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      STYPE:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      BTYPE:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                        inst_i[30:25], inst_i[11:8], 1'b0};
      UTYPE:   imm_o = {inst_i[31:12], 12'h000};
      JTYPE:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                        inst_i[20], inst_i[30:21], 1'b0};
      // CSR immediate forms carry a 5-bit unsigned zimm in the rs1 field
      ZTYPE:   imm_o = {27'h0, inst_i[19:15]};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Two-stage decode-and-extend sequencer: S0 decodes the immediate type,
// S1 holds the extended immediate for the ID/EX boundary.
module imm_decode_ctrl
  import imm_decode_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      imm,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic             s0_valid_q, s0_valid_d;
  logic [31:7]      s0_inst_q, s0_inst_d;
  imm_type_e        s0_type_q, s0_type_d;
  logic             s0_ill_q, s0_ill_d;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_imm_q, s1_imm_d;
  imm_type_e        s1_type_q, s1_type_d;
  logic             s1_ill_q, s1_ill_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  imm_type_e        dec_type;
  logic             dec_ill;
  logic [31:0]      ext_imm;
  logic             s1_adv, s0_adv, accept;

  assign s1_adv   = s1_valid_q & out_ready;
  assign s0_adv   = s0_valid_q & (!s1_valid_q | s1_adv);
  assign in_ready = !flush & (!s0_valid_q | s0_adv);
  assign accept   = in_valid & in_ready;

  always_comb begin
    dec_type = RTYPE;
    dec_ill  = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC:            dec_type = UTYPE;
      OPC_JAL:                       dec_type = JTYPE;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: dec_type = ITYPE;
      OPC_STORE:                     dec_type = STYPE;
      OPC_BRANCH:                    dec_type = BTYPE;
      OPC_OP:                        dec_type = RTYPE;
      OPC_SYSTEM:                    dec_type = inst[14] ? ZTYPE : ITYPE;
      default: begin
        dec_type = RTYPE;
        dec_ill  = 1'b1;
      end
    endcase
  end

  ImmExtend u_imm_extend (
    .inst_i     (s0_inst_q),
    .imm_type_i (s0_type_q),
    .imm_o      (ext_imm)
  );

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_inst_d  = s0_inst_q;
    s0_type_d  = s0_type_q;
    s0_ill_d   = s0_ill_q;
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_type_d  = s1_type_q;
    s1_ill_d   = s1_ill_q;
    cnt_d      = cnt_q;

    // flush wins over accept/advance; in_ready is already low during flush
    if (flush)       s0_valid_d = 1'b0;
    else if (accept) s0_valid_d = 1'b1;
    else if (s0_adv) s0_valid_d = 1'b0;

    if (accept) begin
      s0_inst_d = inst[31:7];
      s0_type_d = dec_type;
      s0_ill_d  = dec_ill;
    end

    if (flush)       s1_valid_d = 1'b0;
    else if (s0_adv) s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    if (s0_adv && !flush) begin
      s1_imm_d  = ext_imm;
      s1_type_d = s0_type_q;
      s1_ill_d  = s0_ill_q;
    end

    if (s1_adv && s1_ill_q && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_inst_q  <= '0;
      s0_type_q  <= RTYPE;
      s0_ill_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_type_q  <= RTYPE;
      s1_ill_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_inst_q  <= s0_inst_d;
      s0_type_q  <= s0_type_d;
      s0_ill_q   <= s0_ill_d;
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_type_q  <= s1_type_d;
      s1_ill_q   <= s1_ill_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = s1_valid_q;
  assign imm         = s1_imm_q;
  assign imm_type    = s1_type_q;
  assign illegal     = s1_ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Bench for imm_decode_ctrl: directed vectors, multi-cycle corner sequences
// and a randomized run against an in-order queue reference model.
module tb_imm_decode_ctrl;
  import imm_decode_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0] inst, imm;
  logic [2:0]  imm_type;
  logic [15:0] illegal_cnt;

  logic        sat_in_valid, sat_in_ready, sat_flush, sat_out_valid, sat_out_ready, sat_illegal;
  logic [31:0] sat_inst, sat_imm;
  logic [2:0]  sat_imm_type;
  logic [1:0]  sat_cnt;

  always #5 clk = ~clk;

  imm_decode_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .imm_type(imm_type), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  imm_decode_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .inst(sat_inst), .flush(sat_flush), .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .imm(sat_imm), .imm_type(sat_imm_type), .illegal(sat_illegal), .illegal_cnt(sat_cnt)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } vec_t;

  int unsigned n_pass = 0, n_total = 0;
  exp_t        q[$];
  int unsigned model_cnt = 0;
  logic        acc_l, beat_l, hold_l;
  exp_t        prev_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Reference built straight from the ISA field layout using signed arithmetic.
  function automatic exp_t ref_model(input logic [31:0] w);
    exp_t e;
    int   sv;
    e.ill = 1'b0;
    case (w[6:0])
      7'h37, 7'h17:        e.typ = UTYPE;
      7'h6F:               e.typ = JTYPE;
      7'h67, 7'h03, 7'h13: e.typ = ITYPE;
      7'h23:               e.typ = STYPE;
      7'h63:               e.typ = BTYPE;
      7'h33:               e.typ = RTYPE;
      7'h73:               e.typ = w[14] ? ZTYPE : ITYPE;
      default: begin e.typ = RTYPE; e.ill = 1'b1; end
    endcase
    sv = 0;
    case (e.typ)
      ITYPE: sv = int'($signed(w[31:20]));
      STYPE: sv = int'($signed({w[31:25], w[11:7]}));
      BTYPE: sv = int'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
      UTYPE: sv = int'(w & 32'hFFFF_F000);
      JTYPE: sv = int'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
      ZTYPE: sv = int'(w[19:15]);
      default: sv = 0;
    endcase
    e.imm = 32'(sv);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                             7'h23, 7'h63, 7'h33, 7'h73, 7'h7F};
    logic [31:0] w;
    w      = $urandom;
    w[6:0] = ops[$urandom_range(10, 0)];
    if ($urandom % 8 == 0) w[6:0] = 7'($urandom);
    return w;
  endfunction

  // One clock cycle: drive at posedge+1, sample just after, score, then step.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    exp_t e;
    chk("illegal_cnt", 32'(illegal_cnt), model_cnt);
    if (hold_l) begin
      chk("hold_imm", imm, prev_out.imm);
      chk("hold_type", 32'(imm_type), 32'(prev_out.typ));
      chk("hold_illegal", 32'(illegal), 32'(prev_out.ill));
    end
    in_valid = v; inst = ins; out_ready = ordy; flush = fl;
    #1;
    acc_l  = in_valid & in_ready;
    beat_l = out_valid & out_ready;
    if (beat_l && !fl) begin
      chk("sb_has_entry", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_imm", imm, e.imm);
        chk("sb_type", 32'(imm_type), 32'(e.typ));
        chk("sb_illegal", 32'(illegal), 32'(e.ill));
        if (e.ill && model_cnt != 32'hFFFF) model_cnt++;
      end
    end
    if (fl) q.delete();
    else if (acc_l) q.push_back(ref_model(ins));
    hold_l   = out_valid & !out_ready & !fl;
    prev_out = '{imm: imm, typ: imm_type, ill: illegal};
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 10 && (q.size() != 0 || out_valid); i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk(nm, q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, 32'(out_valid), 0);
    chk({nm, "_imm"}, imm, 0);
    chk({nm, "_type"}, 32'(imm_type), 32'(RTYPE));
    chk({nm, "_illegal"}, 32'(illegal), 0);
    chk({nm, "_cnt"}, 32'(illegal_cnt), 0);
  endtask

  vec_t        vt [11];
  logic [31:0] s_in  [5] = '{32'h0011_2623, 32'hFE00_0EE3, 32'h1234_5037, 32'hFF9F_F06F, 32'h3002_D073};
  logic [31:0] s_imm [5] = '{32'h0000_000C, 32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFF8, 32'h0000_0005};
  logic [2:0]  s_typ [5];

  initial begin
    int idx, n_acc;
    s_typ = '{STYPE, BTYPE, UTYPE, JTYPE, ZTYPE};
    vt[0]  = '{32'hFFF0_0093, 32'hFFFF_FFFF, ITYPE, 1'b0};
    vt[1]  = '{32'h0011_2623, 32'h0000_000C, STYPE, 1'b0};
    vt[2]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, BTYPE, 1'b0};
    vt[3]  = '{32'h1234_5037, 32'h1234_5000, UTYPE, 1'b0};
    vt[4]  = '{32'hFF9F_F06F, 32'hFFFF_FFF8, JTYPE, 1'b0};
    vt[5]  = '{32'h3002_D073, 32'h0000_0005, ZTYPE, 1'b0};
    vt[6]  = '{32'h3020_0073, 32'h0000_0302, ITYPE, 1'b0};
    vt[7]  = '{32'h0020_8033, 32'h0000_0000, RTYPE, 1'b0};
    vt[8]  = '{32'h0000_1097, 32'h0000_1000, UTYPE, 1'b0};
    vt[9]  = '{32'hFFC1_2083, 32'hFFFF_FFFC, ITYPE, 1'b0};
    vt[10] = '{32'h0000_007F, 32'h0000_0000, RTYPE, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; inst = '0; flush = 1'b0; out_ready = 1'b0;
    sat_in_valid = 1'b0; sat_inst = '0; sat_flush = 1'b0; sat_out_ready = 1'b1;
    hold_l = 1'b0; prev_out = '0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Single-instruction latency against the fixed vector table
    foreach (vt[i]) begin
      cyc(1'b1, vt[i].inst, 1'b1, 1'b0);
      chk("vec_accept", 32'(acc_l), 1);
      chk("vec_lat1_valid", 32'(out_valid), 0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_imm", imm, vt[i].imm);
      chk("vec_type", 32'(imm_type), 32'(vt[i].typ));
      chk("vec_illegal", 32'(illegal), 32'(vt[i].ill));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    drain("vec_drain");

    // Back-to-back stream, one result per cycle
    for (int k = 0; k < 7; k++) begin
      cyc(k < 5, s_in[k < 5 ? k : 0], 1'b1, 1'b0);
      if (k < 5) chk("stream_accept", 32'(acc_l), 1);
      if (k >= 1 && k <= 5) begin
        chk("stream_valid", 32'(out_valid), 1);
        chk("stream_imm", imm, s_imm[k-1]);
        chk("stream_type", 32'(imm_type), 32'(s_typ[k-1]));
      end
    end
    drain("stream_drain");

    // Backpressure: out_ready low for five cycles
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, s_in[n_acc], 1'b0, 1'b0);
      if (acc_l) n_acc++;
      if (k >= 2) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_imm", imm, s_imm[0]);
      end
    end
    chk("stall_accepts", n_acc, 2);
    idx = n_acc;
    for (int k = 0; k < 10 && idx < 5; k++) begin
      cyc(1'b1, s_in[idx], 1'b1, 1'b0);
      if (acc_l) idx++;
    end
    chk("stall_resume_accepts", idx, 5);
    drain("stall_drain");

    // Flush with both stages full and an input on offer
    cyc(1'b1, s_in[0], 1'b0, 1'b0);
    cyc(1'b1, s_in[1], 1'b0, 1'b0);
    chk("flush_pre_full", 32'(out_valid), 1);
    cyc(1'b1, s_in[2], 1'b0, 1'b1);
    chk("flush_no_accept", 32'(acc_l), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    cyc(1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
    chk("flush_next_accept", 32'(acc_l), 1);
    chk("flush_next_lat1", 32'(out_valid), 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("flush_next_valid", 32'(out_valid), 1);
    chk("flush_next_imm", imm, 32'hFFFF_FFFF);
    drain("flush_drain");

    // Illegal counting from a fresh reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    q.delete(); model_cnt = 0; hold_l = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'h0000_007F, 1'b1, 1'b0);
    chk("illegal_seen", 32'(illegal), 1);
    chk("illegal_imm", imm, 0);
    drain("illegal_drain");
    chk("illegal_cnt_3", 32'(illegal_cnt), 3);

    // Asynchronous reset in the middle of a stream
    cyc(1'b1, s_in[0], 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_007F, 1'b1, 1'b0);
    cyc(1'b1, s_in[2], 1'b1, 1'b0);
    chk("midrst_pre_valid", 32'(out_valid), 1);
    #2; rst_n = 1'b0; in_valid = 1'b0; #1;
    check_reset_outputs("midrst");
    q.delete(); model_cnt = 0; hold_l = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the queue model
    for (int k = 0; k < 3000; k++) begin
      logic fl;
      fl = ($urandom % 40 == 0);
      cyc($urandom % 4 != 0, rand_inst(), fl ? 1'b0 : ($urandom % 3 != 0), fl);
    end
    drain("rand_drain");

    // 2-bit counter saturation on the second instance
    sat_in_valid = 1'b1; sat_inst = 32'h0000_007F;
    repeat (6) @(posedge clk);
    #1 sat_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(sat_cnt), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
